// File: rtl/game_pkg.sv
// Shared constants for the game scoring controller: phase encoding and
// the layout of the 8-bit request vector.
package game_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_PLAY  = 2'd1,
    PH_DRAIN = 2'd2,
    PH_OVER  = 2'd3
  } phase_t;

  localparam int N_REQ      = 8;
  localparam int PIPE_BASE  = 0;
  localparam int APPLE_BASE = 4;

endpackage

// File: rtl/game_score_ctrl_rr_arbiter8.sv
// Combinational 8-way round-robin arbiter. Picks the first set request at
// or above ptr, wrapping mod 8. The pointer register lives in the parent.
module rr_arbiter8
  import game_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             gnt_valid,
  output logic [2:0]       gnt_idx
);

  logic [2:0] idx;

  // Cyclic priority search starting at ptr; first hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    idx       = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + 3'(i);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/game_score_ctrl.sv
// Game scoring controller: edge-detects pipe/apple lines into pending
// requests, grants one per cycle round-robin into a saturating score
// accumulator, and tracks game phase and best score.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PH_IDLE  | after reset; rises ignored, score held
// PH_PLAY  | rises queued as pending requests, grants add to score
// PH_DRAIN | game over seen; no new requests, pending ones still scored
// PH_OVER  | all drained; best score updated on entry, score held
module game_score_ctrl
  import game_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int PIPE_PTS  = 1,
  parameter int APPLE_PTS = 1,
  parameter int MAX_SCORE = 4095
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             game_over,
  input  logic [3:0]       sp,
  input  logic [3:0]       eat,
  output logic [WIDTH-1:0] score,
  output logic [WIDTH-1:0] best_score,
  output logic [1:0]       phase,
  output logic             inc,
  output logic             new_best,
  output logic             drop_err,
  output logic             busy
);

  phase_t             state_q, state_d;
  logic [N_REQ-1:0]   level, level_q, rise;
  logic [N_REQ-1:0]   pend_q, pend_d, gnt_mask;
  logic [2:0]         rr_ptr_q;
  logic               gnt_valid;
  logic [2:0]         gnt_idx;
  logic               restart, scoring, do_grant, drop_set, enter_over;
  logic [WIDTH:0]     add_pts, sum;
  logic [WIDTH-1:0]   score_q, score_sat, best_q;
  logic               inc_q, new_best_q, drop_err_q;

  assign level = {eat, sp};
  assign rise  = level & ~level_q;

  rr_arbiter8 u_arb (
    .req       (pend_q),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state, grant qualification, pending update and saturating sum.
  always_comb begin
    state_d    = state_q;
    restart    = 1'b0;
    scoring    = (state_q == PH_PLAY) || (state_q == PH_DRAIN);
    do_grant   = gnt_valid && scoring;
    gnt_mask   = do_grant ? (N_REQ'(1) << gnt_idx) : '0;
    drop_set   = 1'b0;
    enter_over = 1'b0;
    pend_d     = pend_q & ~gnt_mask;

    case (state_q)
      PH_IDLE: begin
        if (start) begin
          state_d = PH_PLAY;
          restart = 1'b1;
        end
      end
      PH_PLAY: begin
        if (start) begin
          restart = 1'b1;
        end else if (game_over) begin
          state_d = PH_DRAIN;
        end
      end
      PH_DRAIN: begin
        if (pend_q == '0) begin
          state_d    = PH_OVER;
          enter_over = 1'b1;
        end
      end
      PH_OVER: begin
        if (start) begin
          state_d = PH_PLAY;
          restart = 1'b1;
        end
      end
      default: state_d = PH_IDLE;
    endcase

    // A rise on a bit granted this cycle simply re-queues it; a rise on a
    // bit still waiting is an event with nowhere to go.
    if (state_q == PH_PLAY) begin
      pend_d   = (pend_q & ~gnt_mask) | rise;
      drop_set = |(rise & pend_q & ~gnt_mask);
    end
    if (restart) pend_d = '0;

    add_pts   = (gnt_idx >= 3'(APPLE_BASE)) ? (WIDTH+1)'(APPLE_PTS)
                                            : (WIDTH+1)'(PIPE_PTS);
    sum       = {1'b0, score_q} + add_pts;
    score_sat = (sum > (WIDTH+1)'(MAX_SCORE)) ? WIDTH'(MAX_SCORE)
                                              : sum[WIDTH-1:0];
  end

  // Phase register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= PH_IDLE;
    else         state_q <= state_d;
  end

  // Edge history, pending requests and round-robin pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q  <= '0;
      pend_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      level_q <= level;
      pend_q  <= pend_d;
      if (do_grant && !restart) rr_ptr_q <= gnt_idx + 3'd1;
    end
  end

  // Score accumulator, change pulse and sticky drop flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      score_q    <= '0;
      inc_q      <= 1'b0;
      drop_err_q <= 1'b0;
    end else if (restart) begin
      score_q    <= '0;
      inc_q      <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      inc_q      <= do_grant && (score_sat != score_q);
      drop_err_q <= drop_err_q | drop_set;
      if (do_grant) score_q <= score_sat;
    end
  end

  // Best score captured on the cycle the game enters OVER.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      best_q     <= '0;
      new_best_q <= 1'b0;
    end else begin
      new_best_q <= enter_over && (score_q > best_q);
      if (enter_over && (score_q > best_q)) best_q <= score_q;
    end
  end

  assign score      = score_q;
  assign best_score = best_q;
  assign phase      = state_q;
  assign inc        = inc_q;
  assign new_best   = new_best_q;
  assign drop_err   = drop_err_q;
  assign busy       = |pend_q;

endmodule
